// File: rtl/redmule_pkg.sv
// RedMulE control-port register map and job-launcher FSM state type.
// Lane helpers place a 32-bit word on the 64-bit peripheral bus by address bit 2.
package redmule_pkg;

  localparam logic [31:0] REDMULE_TRIGGER    = 32'h0000_0000;
  localparam logic [31:0] REDMULE_ACQUIRE    = 32'h0000_0004;
  localparam logic [31:0] REDMULE_STATUS     = 32'h0000_000C;
  localparam logic [31:0] REDMULE_JOB_OFFSET = 32'h0000_0040;

  typedef enum logic [3:0] {
    CFG_IDLE      = 4'd0,
    CFG_ACQ_REQ   = 4'd1,
    CFG_ACQ_RESP  = 4'd2,
    CFG_ACQ_GAP   = 4'd3,
    CFG_WR_REGS   = 4'd4,
    CFG_TRIGGER   = 4'd5,
    CFG_WAIT_DONE = 4'd6,
    CFG_POLL_REQ  = 4'd7,
    CFG_POLL_RESP = 4'd8,
    CFG_DONE      = 4'd9
  } cfg_init_state_t;

  function automatic logic [7:0] lane_be(input logic hi);
    return hi ? 8'hF0 : 8'h0F;
  endfunction

  function automatic logic [63:0] lane_data(input logic hi, input logic [31:0] wdata);
    return hi ? {wdata, 32'h0} : {32'h0, wdata};
  endfunction

endpackage

// File: rtl/redmule_cfg_initiator.sv
// Launches one RedMulE job per accepted descriptor: ACQUIRE (with retry), job regs, TRIGGER, wait for event/STATUS.
// Request fields decode from registered state only, so they hold steady across gnt stalls; one transaction in flight.
module redmule_cfg_initiator
  import redmule_pkg::*;
#(
  parameter int unsigned          N_JOB_REGS    = 16,
  parameter int unsigned          ID_WIDTH      = 8,
  parameter logic [ID_WIDTH-1:0]  ID            = '0,
  parameter logic [31:0]          BASE_ADDR     = 32'h0,
  parameter logic [31:0]          JOB_OFFSET    = REDMULE_JOB_OFFSET,
  parameter int unsigned          POLL_INTERVAL = 64,
  parameter int unsigned          RETRY_GAP     = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         job_valid_i,
  output logic                         job_ready_o,
  input  logic [N_JOB_REGS-1:0][31:0]  job_regs_i,
  input  logic [1:0]                   evt_i,
  output logic                         busy_o,
  output logic                         done_valid_o,
  output logic [7:0]                   done_id_o,
  output logic                         periph_req,
  output logic [31:0]                  periph_add,
  output logic                         periph_wen,
  output logic [7:0]                   periph_be,
  output logic [63:0]                  periph_data,
  output logic [ID_WIDTH-1:0]          periph_id,
  input  logic                         periph_gnt,
  input  logic [63:0]                  periph_r_data,
  input  logic                         periph_r_valid,
  input  logic [ID_WIDTH-1:0]          periph_r_id
);

  localparam int unsigned CNT_MAX = (POLL_INTERVAL > RETRY_GAP) ? POLL_INTERVAL : RETRY_GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = (N_JOB_REGS > 1) ? $clog2(N_JOB_REGS) : 1;

  cfg_init_state_t             state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        evt_seen_q, evt_seen_d;
  logic [7:0]                  job_id_q, job_id_d;
  logic [7:0]                  done_id_q;
  logic [N_JOB_REGS-1:0][31:0] regs_q;
  logic                        latch_job;
  logic                        rsp_ok;
  logic [31:0]                 rsp_dat;
  logic [31:0]                 wdata;
  logic                        unused_bits;

  assign rsp_ok      = periph_r_valid && (periph_r_id == ID);
  assign rsp_dat     = periph_r_data[31:0];
  assign unused_bits = ^{evt_i[1], periph_r_data[63:32]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= CFG_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      evt_seen_q <= 1'b0;
      job_id_q   <= '0;
      done_id_q  <= '0;
      regs_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      evt_seen_q <= evt_seen_d;
      job_id_q   <= job_id_d;
      if (latch_job) regs_q <= job_regs_i;
      // Load on entry so the ID is valid alongside the done pulse.
      if (state_d == CFG_DONE) done_id_q <= job_id_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    evt_seen_d = evt_seen_q;
    job_id_d   = job_id_q;
    latch_job  = 1'b0;
    case (state_q)
      CFG_IDLE: begin
        if (job_valid_i) begin
          latch_job = 1'b1;
          state_d   = CFG_ACQ_REQ;
        end
      end
      CFG_ACQ_REQ: if (periph_gnt) state_d = CFG_ACQ_RESP;
      CFG_ACQ_RESP: begin
        if (rsp_ok) begin
          if (rsp_dat[31]) begin
            cnt_d   = '0;
            state_d = CFG_ACQ_GAP;
          end else begin
            job_id_d = rsp_dat[7:0];
            idx_d    = '0;
            state_d  = CFG_WR_REGS;
          end
        end
      end
      CFG_ACQ_GAP: begin
        if (cnt_q == CNT_W'(RETRY_GAP - 1)) state_d = CFG_ACQ_REQ;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      CFG_WR_REGS: begin
        if (periph_gnt) begin
          if (idx_q == IDX_W'(N_JOB_REGS - 1)) state_d = CFG_TRIGGER;
          else idx_d = idx_q + IDX_W'(1);
        end
      end
      CFG_TRIGGER: begin
        if (periph_gnt) begin
          cnt_d   = '0;
          state_d = CFG_WAIT_DONE;
        end
      end
      CFG_WAIT_DONE: begin
        if (evt_i[0]) begin
          state_d = CFG_DONE;
        end else if (cnt_q == CNT_W'(POLL_INTERVAL - 1)) begin
          evt_seen_d = 1'b0;
          state_d    = CFG_POLL_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CFG_POLL_REQ: begin
        evt_seen_d = evt_seen_q | evt_i[0];
        // An ungranted poll may be abandoned; a granted one must be drained.
        if (periph_gnt) state_d = CFG_POLL_RESP;
        else if (evt_seen_q || evt_i[0]) state_d = CFG_DONE;
      end
      CFG_POLL_RESP: begin
        evt_seen_d = evt_seen_q | evt_i[0];
        if (rsp_ok) begin
          if ((rsp_dat == 32'h0) || evt_seen_q || evt_i[0]) begin
            state_d = CFG_DONE;
          end else begin
            cnt_d   = '0;
            state_d = CFG_WAIT_DONE;
          end
        end
      end
      CFG_DONE: state_d = CFG_IDLE;
      default:  state_d = CFG_IDLE;
    endcase
  end

  always_comb begin
    periph_req = 1'b0;
    periph_add = '0;
    periph_wen = 1'b1;
    wdata      = '0;
    case (state_q)
      CFG_ACQ_REQ: begin
        periph_req = 1'b1;
        periph_add = BASE_ADDR + REDMULE_ACQUIRE;
      end
      CFG_WR_REGS: begin
        periph_req = 1'b1;
        periph_wen = 1'b0;
        periph_add = BASE_ADDR + JOB_OFFSET + {{(30 - IDX_W){1'b0}}, idx_q, 2'b00};
        wdata      = regs_q[idx_q];
      end
      CFG_TRIGGER: begin
        periph_req = 1'b1;
        periph_wen = 1'b0;
        periph_add = BASE_ADDR + REDMULE_TRIGGER;
      end
      CFG_POLL_REQ: begin
        periph_req = 1'b1;
        periph_add = BASE_ADDR + REDMULE_STATUS;
      end
      default: ;
    endcase
  end

  assign periph_be    = periph_req ? lane_be(periph_add[2]) : 8'h00;
  assign periph_data  = (periph_req && !periph_wen) ? lane_data(periph_add[2], wdata) : 64'h0;
  assign periph_id    = ID;
  assign job_ready_o  = (state_q == CFG_IDLE);
  assign busy_o       = (state_q != CFG_IDLE);
  assign done_valid_o = (state_q == CFG_DONE);
  assign done_id_o    = done_id_q;

endmodule

// File: tb/tb_redmule_cfg_initiator.sv
// Job-launcher bench: bus responder with queued ACQUIRE/STATUS replies, transaction log compared to an expected job sequence.
module tb_redmule_cfg_initiator;
  import redmule_pkg::*;

  localparam int          N    = 4;
  localparam int          PI   = 8;
  localparam int          RG   = 3;
  localparam logic [7:0]  ID   = 8'h00;
  localparam logic [31:0] BASE = 32'h0;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b1;
  logic                  job_valid_i = 1'b0;
  logic                  job_ready_o;
  logic [N-1:0][31:0]    job_regs_i = '0;
  logic [1:0]            evt_i = 2'b00;
  logic                  busy_o, done_valid_o;
  logic [7:0]            done_id_o;
  logic                  periph_req, periph_wen, periph_gnt;
  logic [31:0]           periph_add;
  logic [7:0]            periph_be;
  logic [63:0]           periph_data;
  logic [7:0]            periph_id;
  logic [63:0]           periph_r_data = '0;
  logic                  periph_r_valid = 1'b0;
  logic [7:0]            periph_r_id = ID;

  redmule_cfg_initiator #(
    .N_JOB_REGS(N), .ID_WIDTH(8), .ID(ID), .BASE_ADDR(BASE),
    .JOB_OFFSET(REDMULE_JOB_OFFSET), .POLL_INTERVAL(PI), .RETRY_GAP(RG)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_regs_i(job_regs_i), .evt_i(evt_i), .busy_o(busy_o), .done_valid_o(done_valid_o),
    .done_id_o(done_id_o), .periph_req(periph_req), .periph_add(periph_add),
    .periph_wen(periph_wen), .periph_be(periph_be), .periph_data(periph_data),
    .periph_id(periph_id), .periph_gnt(periph_gnt), .periph_r_data(periph_r_data),
    .periph_r_valid(periph_r_valid), .periph_r_id(periph_r_id)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] add;
    logic        wen;
    logic [7:0]  be;
    logic [63:0] data;
    int          cyc;
  } txn_t;

  typedef struct {
    int          n_locked;
    logic [31:0] lock_val;
    logic [31:0] acq_ok;
    int          n_busy;
    bit          use_evt;
    int          evt_delay;
    bit          gnt_rand;
    logic [7:0]  exp_id;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  txn_t        log_q[$];
  logic [31:0] acq_q[$];
  logic [31:0] stat_q[$];
  int          rsp_cnt = 0;
  int          rsp_delay = 1;
  bit          spurious = 0;
  bit          gnt_rand = 0;
  logic [31:0] rsp_dat = '0;
  bit          trig_seen = 0, stat_seen = 0, wr_seen = 0;
  logic        gnt_en = 1'b0;
  bit          stall_prev = 0;
  txn_t        held;

  assign periph_gnt = gnt_en;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk_i);
    #1;
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Peripheral slave: grants, logs handshakes, answers reads rsp_delay cycles later.
  always @(negedge clk_i) begin
    periph_r_valid = 1'b0;
    periph_r_id    = ID;
    periph_r_data  = '0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        periph_r_valid = 1'b1;
        periph_r_data  = {32'hDEAD_BEEF, rsp_dat};
      end else if (spurious) begin
        periph_r_valid = 1'b1;
        periph_r_id    = ID ^ 8'h5A;
      end
    end
    if (stall_prev)
      chk("stall_hold", {periph_req, periph_add, periph_wen, periph_be, periph_data},
          {1'b1, held.add, held.wen, held.be, held.data});
    gnt_en     = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    stall_prev = periph_req && !gnt_en;
    held       = '{periph_add, periph_wen, periph_be, periph_data, cyc};
    if (periph_req && gnt_en) begin
      log_q.push_back('{periph_add, periph_wen, periph_be, periph_data, cyc});
      if (!periph_wen) wr_seen = 1;
      if (!periph_wen && periph_add == BASE + REDMULE_TRIGGER) trig_seen = 1;
      if (periph_wen) begin
        rsp_cnt = rsp_delay;
        if (periph_add == BASE + REDMULE_ACQUIRE) begin
          rsp_dat = (acq_q.size() > 0) ? acq_q.pop_front() : 32'h0;
        end else begin
          stat_seen = 1;
          rsp_dat   = (stat_q.size() > 0) ? stat_q.pop_front() : 32'h0;
        end
      end
    end
  end

  function automatic txn_t mk(input logic [31:0] add, input logic wen, input logic [31:0] w);
    txn_t t;
    t.add  = add;
    t.wen  = wen;
    t.be   = add[2] ? 8'hF0 : 8'h0F;
    t.data = wen ? 64'h0 : (add[2] ? {w, 32'h0} : {32'h0, w});
    t.cyc  = 0;
    return t;
  endfunction

  task automatic clear_bus;
    log_q.delete();
    acq_q.delete();
    stat_q.delete();
    trig_seen = 0;
    stat_seen = 0;
    wr_seen   = 0;
  endtask

  task automatic start_job(input logic [N-1:0][31:0] regs);
    tick;
    chk("ready_idle", job_ready_o, 1'b1);
    job_regs_i  = regs;
    job_valid_i = 1'b1;
    tick;
    job_valid_i = 1'b0;
    job_regs_i  = ~regs;
    chk("acq_req_lat", {periph_req, periph_wen, periph_add}, {1'b1, 1'b1, BASE + REDMULE_ACQUIRE});
    chk("busy_accept", {busy_o, job_ready_o}, 2'b10);
  endtask

  task automatic run_job(input vec_t v);
    logic [N-1:0][31:0] regs;
    txn_t exp_q[$];
    bit   got;
    int   n_stat, prev_a, prev_s;
    clear_bus();
    gnt_rand = v.gnt_rand;
    repeat (v.n_locked) acq_q.push_back(v.lock_val);
    acq_q.push_back(v.acq_ok);
    repeat (v.n_busy) stat_q.push_back(32'h1 + ($urandom & 32'hFF));
    stat_q.push_back(32'h0);
    for (int i = 0; i < N; i++) regs[i] = $urandom;
    start_job(regs);
    if (v.use_evt) begin
      for (int k = 0; k < 500 && !trig_seen; k++) tick;
      chk("trigger_seen", trig_seen, 1'b1);
      repeat (v.evt_delay + 1) tick;
      evt_i = 2'b01;
      tick;
      evt_i = 2'b00;
      chk("evt_to_done", done_valid_o, 1'b1);
    end else begin
      got = 0;
      for (int k = 0; k < 3000 && !got; k++) begin
        tick;
        got = done_valid_o;
      end
      chk("done_seen", got, 1'b1);
    end
    chk("done_id", done_id_o, v.exp_id);
    tick;
    chk("done_pulse_end", {done_valid_o, busy_o, job_ready_o}, 3'b001);
    chk("done_id_hold", done_id_o, v.exp_id);
    n_stat = v.use_evt ? 0 : v.n_busy + 1;
    for (int k = 0; k <= v.n_locked; k++) exp_q.push_back(mk(BASE + REDMULE_ACQUIRE, 1'b1, 32'h0));
    for (int i = 0; i < N; i++) exp_q.push_back(mk(BASE + REDMULE_JOB_OFFSET + 32'(4 * i), 1'b0, regs[i]));
    exp_q.push_back(mk(BASE + REDMULE_TRIGGER, 1'b0, 32'h0));
    for (int s = 0; s < n_stat; s++) exp_q.push_back(mk(BASE + REDMULE_STATUS, 1'b1, 32'h0));
    chk("txn_count", log_q.size(), exp_q.size());
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
      chk($sformatf("txn%0d", i), {log_q[i].add, log_q[i].wen, log_q[i].be, log_q[i].data},
          {exp_q[i].add, exp_q[i].wen, exp_q[i].be, exp_q[i].data});
    prev_a = -1;
    prev_s = -1;
    foreach (log_q[i]) begin
      if (log_q[i].wen && log_q[i].add == BASE + REDMULE_ACQUIRE) begin
        if (prev_a >= 0) chk("acq_gap", (log_q[i].cyc - prev_a) > RG, 1'b1);
        prev_a = log_q[i].cyc;
      end
      if (log_q[i].wen && log_q[i].add == BASE + REDMULE_STATUS) begin
        if (prev_s >= 0) chk("poll_gap", (log_q[i].cyc - prev_s) >= PI, 1'b1);
        prev_s = log_q[i].cyc;
      end
    end
  endtask

  task automatic evt_during_status;
    logic [N-1:0][31:0] regs;
    bit real_rsp;
    int n_stat;
    clear_bus();
    gnt_rand  = 0;
    rsp_delay = 4;
    spurious  = 1;
    acq_q.push_back(32'h0000_0042);
    stat_q.push_back(32'h0000_0005);
    for (int i = 0; i < N; i++) regs[i] = $urandom;
    start_job(regs);
    for (int k = 0; k < 500 && !stat_seen; k++) tick;
    chk("status_seen", stat_seen, 1'b1);
    tick;
    evt_i = 2'b01;
    real_rsp = 0;
    for (int k = 0; k < 10 && !real_rsp; k++) begin
      chk("no_early_done", done_valid_o, 1'b0);
      real_rsp = periph_r_valid && (periph_r_id == ID);
      if (!real_rsp) begin
        tick;
        evt_i = 2'b00;
      end
    end
    evt_i = 2'b00;
    chk("status_rsp_seen", real_rsp, 1'b1);
    tick;
    chk("evt_latched_done", {done_valid_o, done_id_o}, {1'b1, 8'h42});
    tick;
    chk("evt_done_end", done_valid_o, 1'b0);
    n_stat = 0;
    foreach (log_q[i]) if (log_q[i].wen && log_q[i].add == BASE + REDMULE_STATUS) n_stat++;
    chk("evt_status_reads", n_stat, 1);
    rsp_delay = 1;
    spurious  = 0;
  endtask

  task automatic reset_mid_write;
    logic [N-1:0][31:0] regs;
    clear_bus();
    gnt_rand = 0;
    acq_q.push_back(32'h0000_0007);
    for (int i = 0; i < N; i++) regs[i] = $urandom;
    start_job(regs);
    for (int k = 0; k < 200 && !wr_seen; k++) tick;
    chk("pre_rst_write", {periph_req, periph_wen}, 2'b10);
    rst_i = 1'b1;
    #1;
    chk("rst_req_drop", {periph_req, busy_o, done_valid_o}, 3'b000);
    tick;
    rst_i = 1'b0;
    clear_bus();
    tick;
    chk("post_rst_ready", {job_ready_o, busy_o, periph_req}, 3'b100);
  endtask

  vec_t tbl[5];
  vec_t rv;

  initial begin
    tbl[0] = '{0, 32'h0,         32'h0000_0003, 0, 1'b1, 2, 1'b0, 8'h03};
    tbl[1] = '{2, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b1, 0, 1'b0, 8'h01};
    tbl[2] = '{0, 32'h0,         32'h0000_00A5, 1, 1'b0, 0, 1'b0, 8'hA5};
    tbl[3] = '{1, 32'h8000_0000, 32'h0000_1234, 0, 1'b1, 4, 1'b1, 8'h34};
    tbl[4] = '{0, 32'h0,         32'h7FFF_FF5C, 2, 1'b0, 0, 1'b1, 8'h5C};

    repeat (2) tick;
    chk("rst_outs_held",
        {job_ready_o, busy_o, done_valid_o, done_id_o, periph_req, periph_add, periph_be, periph_data, periph_wen},
        {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 8'h00, 64'h0, 1'b1});
    rst_i = 1'b0;
    tick;
    chk("rst_outs_released",
        {job_ready_o, busy_o, done_valid_o, done_id_o, periph_req, periph_add, periph_be, periph_data, periph_wen},
        {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 8'h00, 64'h0, 1'b1});

    for (int t = 0; t < 5; t++) run_job(tbl[t]);

    evt_during_status();
    reset_mid_write();
    run_job(tbl[0]);

    for (int r = 0; r < 6; r++) begin
      rv.n_locked  = $urandom_range(0, 2);
      rv.lock_val  = 32'h8000_0000 | $urandom;
      rv.acq_ok    = $urandom & 32'h7FFF_FFFF;
      rv.n_busy    = $urandom_range(0, 2);
      rv.use_evt   = 1'($urandom_range(0, 1));
      rv.evt_delay = $urandom_range(0, 5);
      rv.gnt_rand  = 1'($urandom_range(0, 1));
      rv.exp_id    = rv.acq_ok[7:0];
      run_job(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
